// File: rtl/frame_pkg.sv
// Shared constants and types for the RGB frame-buffer read path.
package frame_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADD_WIDTH  = 12;
  localparam int unsigned IMG_W      = 64;
  localparam int unsigned IMG_H      = 64;
  localparam int unsigned COL_BITS   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_BITS   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0] g;
    logic [DATA_WIDTH-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/frame_rd_if.sv
// Control, frame-buffer read port and pixel stream of the frame reader.
interface frame_rd_if #(
  parameter int unsigned DATA_WIDTH = frame_pkg::DATA_WIDTH,
  parameter int unsigned ADD_WIDTH  = frame_pkg::ADD_WIDTH,
  parameter int unsigned COL_W      = frame_pkg::COL_BITS,
  parameter int unsigned ROW_W      = frame_pkg::ROW_BITS
);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic [ADD_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_r;
  logic [DATA_WIDTH-1:0] mem_g;
  logic [DATA_WIDTH-1:0] mem_b;
  logic [DATA_WIDTH-1:0] out_r;
  logic [DATA_WIDTH-1:0] out_g;
  logic [DATA_WIDTH-1:0] out_b;
  logic [COL_W-1:0]      out_col;
  logic [ROW_W-1:0]      out_row;
  logic                  out_eol;
  logic                  out_eof;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  start, mem_r, mem_g, mem_b, out_ready,
    output busy, done, mem_addr, out_r, out_g, out_b,
           out_col, out_row, out_eol, out_eof, out_valid
  );

  modport slave (
    output start, mem_r, mem_g, mem_b, out_ready,
    input  busy, done, mem_addr, out_r, out_g, out_b,
           out_col, out_row, out_eol, out_eof, out_valid
  );

endinterface

// File: rtl/pixel_fifo2.sv
// Two-entry output FIFO; the head entry drives the pixel stream directly.
module pixel_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + 2'(i_push) - 2'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/frame_rgb_reader.sv
// Raster-scan read master for the RGB frame buffer with a valid/ready pixel stream.
// FRAME_READER_MIRROR_EN: scan each row right-to-left in memory (horizontal mirror).
module frame_rgb_reader
  import frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = frame_pkg::DATA_WIDTH,
  parameter int unsigned ADD_WIDTH  = frame_pkg::ADD_WIDTH,
  parameter int unsigned IMG_W      = frame_pkg::IMG_W,
  parameter int unsigned IMG_H      = frame_pkg::IMG_H
) (
  input  logic       clk,
  input  logic       rst,
  frame_rd_if.master bus
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0] g;
    logic [DATA_WIDTH-1:0] b;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic                  eol;
    logic                  eof;
  } pix_t;

  localparam int unsigned PIX_W = $bits(pix_t);

  function automatic logic [ADD_WIDTH-1:0] pixel_addr(input logic [COL_W-1:0] col,
                                                      input logic [ROW_W-1:0] row);
`ifdef FRAME_READER_MIRROR_EN
    return ADD_WIDTH'(row) * ADD_WIDTH'(IMG_W) + ADD_WIDTH'(IMG_W - 1) - ADD_WIDTH'(col);
`else
    return ADD_WIDTH'(row) * ADD_WIDTH'(IMG_W) + ADD_WIDTH'(col);
`endif
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic [ADD_WIDTH-1:0] r_addr;
  logic [COL_W-1:0]     r_col;
  logic [ROW_W-1:0]     r_row;
  logic                 r_issued_all;
  logic                 r_inflight;
  logic [COL_W-1:0]     r_tag_col;
  logic [ROW_W-1:0]     r_tag_row;
  logic                 r_tag_eol;
  logic                 r_tag_eof;
  logic [COL_W-1:0]     w_col_nxt;
  logic [ROW_W-1:0]     w_row_nxt;
  logic                 w_last_col;
  logic                 w_last_pix;
  logic                 w_enter;
  logic                 w_issue;
  logic                 w_pop;
  logic                 w_valid;
  logic [2:0]           w_occ;
  logic [1:0]           w_count;
  pix_t                 w_push_pix;
  pix_t                 w_head;

  assign w_valid    = (w_count != 2'd0);
  assign w_pop      = w_valid && bus.out_ready;
  assign w_enter    = (r_state == IDLE) && bus.start;
  assign w_last_col = (r_col == COL_W'(IMG_W - 1));
  assign w_last_pix = w_last_col && (r_row == ROW_W'(IMG_H - 1));
  assign w_col_nxt  = w_last_col ? '0 : r_col + COL_W'(1);
  assign w_row_nxt  = !w_last_col ? r_row : (w_last_pix ? '0 : r_row + ROW_W'(1));

  // Keep buffered + in-flight pixels within the 2-entry FIFO, counting this cycle's pop.
  assign w_occ   = 3'(w_count) + 3'(r_inflight);
  assign w_issue = (r_state == STREAM) && !r_issued_all && (w_occ < 3'(2) + 3'(w_pop));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = STREAM;
      STREAM:  if (w_pop && w_head.eof) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode, registered alongside the state
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    if (w_state_nxt == STREAM) w_busy_nxt = 1'b1;
    if (w_state_nxt == DONE)   w_done_nxt = 1'b1;
  end

  // Address/tag counters always name the pixel at r_addr; tags follow a read for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_issued_all <= 1'b0;
      r_inflight   <= 1'b0;
      r_tag_col    <= '0;
      r_tag_row    <= '0;
      r_tag_eol    <= 1'b0;
      r_tag_eof    <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_enter) begin
        r_addr       <= pixel_addr(COL_W'(0), ROW_W'(0));
        r_col        <= '0;
        r_row        <= '0;
        r_issued_all <= 1'b0;
      end else if (w_issue) begin
        r_addr       <= pixel_addr(w_col_nxt, w_row_nxt);
        r_col        <= w_col_nxt;
        r_row        <= w_row_nxt;
        r_issued_all <= w_last_pix;
        r_tag_col    <= r_col;
        r_tag_row    <= r_row;
        r_tag_eol    <= w_last_col;
        r_tag_eof    <= w_last_pix;
      end
    end
  end

  always_comb begin
    w_push_pix     = '0;
    w_push_pix.r   = bus.mem_r;
    w_push_pix.g   = bus.mem_g;
    w_push_pix.b   = bus.mem_b;
    w_push_pix.col = r_tag_col;
    w_push_pix.row = r_tag_row;
    w_push_pix.eol = r_tag_eol;
    w_push_pix.eof = r_tag_eof;
  end

  pixel_fifo2 #(.W(PIX_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (w_push_pix),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.mem_addr  = r_addr;
  assign bus.out_r     = w_head.r;
  assign bus.out_g     = w_head.g;
  assign bus.out_b     = w_head.b;
  assign bus.out_col   = w_head.col;
  assign bus.out_row   = w_head.row;
  assign bus.out_eol   = w_head.eol;
  assign bus.out_eof   = w_head.eof;
  assign bus.out_valid = w_valid;

endmodule

// File: tb/tb_frame_rgb_reader.sv
// Bench for frame_rgb_reader: registered RAM model, scoreboard queue of expected beats.
module tb_frame_rgb_reader;
  import frame_pkg::*;

  localparam int unsigned NPIX = IMG_W * IMG_H;

  typedef struct {
    int low_pct;
    bit poke;
    bit timed;
    int exp_first;
    int exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic [63:0] q[$];
  vec_t tbl[3];

  frame_rd_if bus();

  frame_rgb_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ram_word(input logic [ADD_WIDTH-1:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return {lo, ~lo, a[11:4]};
  endfunction

  always_ff @(posedge clk) begin
    {bus.mem_r, bus.mem_g, bus.mem_b} <= ram_word(bus.mem_addr);
  end

  function automatic logic [63:0] exp_beat(input int n);
    logic [COL_BITS-1:0]  col;
    logic [ROW_BITS-1:0]  row;
    logic [ADD_WIDTH-1:0] a;
    col = COL_BITS'(n % int'(IMG_W));
    row = ROW_BITS'(n / int'(IMG_W));
`ifdef FRAME_READER_MIRROR_EN
    a = ADD_WIDTH'(int'(row) * int'(IMG_W) + int'(IMG_W) - 1 - int'(col));
`else
    a = ADD_WIDTH'(n);
`endif
    return 64'({ram_word(a), col, row, (col == COL_BITS'(IMG_W - 1)), (n == int'(NPIX) - 1)});
  endfunction

  function automatic logic [63:0] cur_beat();
    return 64'({bus.out_r, bus.out_g, bus.out_b, bus.out_col, bus.out_row,
                bus.out_eol, bus.out_eof});
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", name, got, exp, $time);
    end
  endtask

  // One frame: optional random stalls, optional start pokes while busy and in DONE.
  task automatic run_frame(input vec_t v);
    int c, beats, first, done_c;
    bit stall_prev, poke_next;
    logic [63:0] held, got, e;
    q.delete();
    for (int i = 0; i < int'(NPIX); i++) q.push_back(exp_beat(i));
    beats = 0; first = -1; done_c = -1; stall_prev = 1'b0; poke_next = 1'b0; held = '0;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.out_ready = (int'($urandom_range(99)) >= v.low_pct);
    c = 0;
    while (c < 30000) begin
      @(negedge clk);
      got = cur_beat();
      if (stall_prev) check("stall_hold", got, held);
      if (bus.out_valid && first < 0) first = c;
      if (bus.done && done_c < 0) done_c = c;
      poke_next = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("extra_beat", 64'(beats), 64'(NPIX));
        else begin
          e = q.pop_front();
          check("beat", got, e);
        end
        beats++;
        if (bus.out_eof) poke_next = v.poke;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held = got;
      if (done_c >= 0 && c >= done_c + 20) break;
      @(posedge clk); #1;
      c++;
      bus.start     = (v.poke && (c == 1 || c == 700)) || poke_next;
      bus.out_ready = (int'($urandom_range(99)) >= v.low_pct);
    end
    bus.start = 1'b0;
    check("beat_count", 64'(beats), 64'(NPIX));
    check("done_seen", 64'(done_c >= 0), 64'(1));
    check("idle_after", 64'({bus.busy, bus.out_valid, bus.done}), 64'(0));
    if (v.timed) begin
      check("first_valid_cycle", 64'(first), 64'(v.exp_first));
      check("done_cycle", 64'(done_c), 64'(v.exp_done));
    end
  endtask

  initial begin
    int beats;
    tbl[0] = '{0,  1'b0, 1'b1, 3, 4099};
    tbl[1] = '{30, 1'b0, 1'b0, 0, 0};
    tbl[2] = '{30, 1'b1, 1'b0, 0, 0};

    rst = 1'b1; bus.start = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_data", cur_beat(), 64'(0));
    for (int i = 0; i < 20; i++) begin
      check("idle_ctl", 64'({bus.out_valid, bus.busy, bus.done, bus.mem_addr}), 64'(0));
      @(negedge clk);
    end

    for (int t = 0; t < 3; t++) run_frame(tbl[t]);

    // Reset in the middle of a frame, then a clean frame from address 0.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.out_ready = 1'b1;
    beats = 0;
    for (int c = 0; c < 2000 && beats < 1000; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        check("pre_reset_beat", cur_beat(), exp_beat(beats));
        beats++;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    check("pre_reset_count", 64'(beats), 64'(1000));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ctl", 64'({bus.out_valid, bus.busy, bus.done, bus.mem_addr}), 64'(0));
    repeat (3) begin
      @(negedge clk);
      check("post_reset_quiet", 64'({bus.out_valid, bus.busy}), 64'(0));
    end
    run_frame(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
